// File: rtl/ws2812b_decoder.sv
// WS2812B serial line decoder: captures one 96-bit frame (4 LEDs x GRB) per RET.
// Define WS2812B_FORWARD_EN to add the daisy-chain forwarding output dout.
module ws2812b_decoder #(
    parameter int BIT_THRESH = 60,
    parameter int MIN_HIGH   = 20,
    parameter int MAX_HIGH   = 100,
    parameter int RET_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [95:0] frame,
    output logic        frame_valid,
    output logic        err,
`ifdef WS2812B_FORWARD_EN
    output logic        dout,
`endif
    output logic        busy
);

    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(RET_CYCLES + 1);

    localparam logic [HW-1:0] HI_THR = HW'(BIT_THRESH);
    localparam logic [HW-1:0] HI_MIN = HW'(MIN_HIGH);
    localparam logic [HW-1:0] HI_MAX = HW'(MAX_HIGH);
    localparam logic [LW-1:0] LO_RET = LW'(RET_CYCLES);
    localparam logic [6:0]    BITS   = 7'd96;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [HW-1:0] r_hi_cnt;
    logic [LW-1:0] r_lo_cnt;
    logic [6:0]    r_bit_cnt;
    logic [95:0]   r_shreg;
    logic [95:0]   r_frame;
    logic          r_valid;
    logic          r_err;
    logic          r_busy;

    logic          w_ds;
    logic          w_bit;
    logic          w_short;
    logic [LW-1:0] w_lo_next;

    assign w_ds      = r_sync2;
    assign w_bit     = (r_hi_cnt >= HI_THR);
    assign w_short   = (r_hi_cnt < HI_MIN);
    assign w_lo_next = (r_lo_cnt == LO_RET) ? r_lo_cnt
                                            : r_lo_cnt + 1'b1;

    assign frame       = r_frame;
    assign frame_valid = r_valid;
    assign err         = r_err;
    assign busy        = r_busy;

`ifdef WS2812B_FORWARD_EN
    logic r_fwd;
    // Pass the line on only once this LED chain segment is full.
    assign dout = r_fwd & w_ds;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= SYNC;
            r_hi_cnt  <= '0;
            r_lo_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_frame   <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
`ifdef WS2812B_FORWARD_EN
            r_fwd     <= 1'b0;
`endif
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            unique case (r_state)
                SYNC: begin
                    if (w_ds) begin
                        r_lo_cnt <= '0;
                    end else begin
                        r_lo_cnt <= w_lo_next;
                        if (w_lo_next == LO_RET)
                            r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_ds) begin
                        r_state   <= MEAS_HIGH;
                        r_hi_cnt  <= HW'(1);
                        r_bit_cnt <= '0;
                        r_shreg   <= '0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef WS2812B_FORWARD_EN
                        r_fwd     <= 1'b0;
`endif
                    end
                end
                MEAS_HIGH: begin
                    if (w_ds) begin
                        // Overlong pulse: line is not a WS2812B stream, resync.
                        if (r_hi_cnt == HI_MAX) begin
                            r_err    <= 1'b1;
                            r_state  <= SYNC;
                            r_lo_cnt <= '0;
                            r_busy   <= 1'b0;
`ifdef WS2812B_FORWARD_EN
                            r_fwd    <= 1'b0;
`endif
                        end else begin
                            r_hi_cnt <= r_hi_cnt + 1'b1;
                        end
                    end else begin
                        if (w_short)
                            r_err <= 1'b1;
                        if (r_bit_cnt != BITS) begin
                            r_shreg   <= {r_shreg[94:0], w_bit};
                            r_bit_cnt <= r_bit_cnt + 7'd1;
                        end
`ifdef WS2812B_FORWARD_EN
                        if (r_bit_cnt == BITS - 7'd1)
                            r_fwd <= 1'b1;
`endif
                        r_state  <= MEAS_LOW;
                        r_lo_cnt <= LW'(1);
                    end
                end
                MEAS_LOW: begin
                    if (w_ds) begin
                        r_state  <= MEAS_HIGH;
                        r_hi_cnt <= HW'(1);
                    end else begin
                        r_lo_cnt <= w_lo_next;
                        if (w_lo_next == LO_RET) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`ifdef WS2812B_FORWARD_EN
                            r_fwd   <= 1'b0;
`endif
                            if (r_bit_cnt == BITS) begin
                                if (!r_err) begin
                                    r_frame <= r_shreg;
                                    r_valid <= 1'b1;
                                end
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_decoder.sv
// Self-checking bench for ws2812b_decoder (scaled timing parameters).
// Forward-mode checks are compiled in when WS2812B_FORWARD_EN is defined.
module tb_ws2812b_decoder;

    localparam int THR  = 12;
    localparam int MINH = 4;
    localparam int MAXH = 20;
    localparam int RET  = 200;
    localparam int T1H  = 16;
    localparam int T1L  = 9;
    localparam int T0H  = 8;
    localparam int T0L  = 17;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic [95:0] frame;
    logic        frame_valid;
    logic        err;
    logic        busy;
`ifdef WS2812B_FORWARD_EN
    logic        dout;
`endif

    ws2812b_decoder #(
        .BIT_THRESH(THR),
        .MIN_HIGH  (MINH),
        .MAX_HIGH  (MAXH),
        .RET_CYCLES(RET)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .frame      (frame),
        .frame_valid(frame_valid),
        .err        (err),
`ifdef WS2812B_FORWARD_EN
        .dout       (dout),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          vcnt = 0;
    int          vcyc = 0;
    int          c_last = 0;
    int          q_hw[$];
    int          q_lw[$];
    logic [95:0] m_frame = '0;
    bit          busy_chk = 1'b0;
    bit          fwd_arm = 1'b0;
    int          fwd_mode = 0;

    typedef struct {
        int nb;
        int hw;
        bit v;
        bit e;
        bit b;
    } vec_t;
    vec_t tbl[8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            vcnt = vcnt + 1;
            vcyc = cyc;
        end
    end

`ifdef WS2812B_FORWARD_EN
    logic h1 = 1'b0;
    logic h2 = 1'b0;
    int   bad0 = 0;
    int   bad1 = 0;
    int   fhi = 0;
    always @(posedge clk) begin
        h1 <= din;
        h2 <= h1;
    end
    always @(negedge clk) begin
        if (fwd_mode == 1 && dout !== 1'b0) bad0 = bad0 + 1;
        if (fwd_mode == 2) begin
            if (dout !== h2) bad1 = bad1 + 1;
            if (dout === 1'b1) fhi = fhi + 1;
        end
    end
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic q_bits(input logic [95:0] d, input int n);
        bit b;
        q_hw.delete();
        q_lw.delete();
        for (int i = 0; i < n; i++) begin
            if (i < 96) b = d[95-i];
            else b = 1'($urandom_range(0, 1));
            q_hw.push_back(b ? T1H : T0H);
            q_lw.push_back(b ? T1L : T0L);
        end
    endtask

    // Frame outcome from the pulse list: abort, short pulses, bit count.
    function automatic void model(output bit v, output bit e,
                                  output logic [95:0] f);
        int n;
        bit ab;
        bit sh;
        n = 0;
        ab = 1'b0;
        sh = 1'b0;
        f = '0;
        foreach (q_hw[i]) begin
            if (!ab) begin
                if (q_hw[i] > MAXH) ab = 1'b1;
                else begin
                    if (q_hw[i] < MINH) sh = 1'b1;
                    if (n < 96) begin
                        f[95-n] = (q_hw[i] >= THR);
                        n++;
                    end
                end
            end
        end
        e = ab | sh | (n < 96);
        v = !e;
    endfunction

    task automatic send_q(input int tail);
        int n;
        n = q_hw.size();
        for (int i = 0; i < n; i++) begin
            if (fwd_arm && i == 96) fwd_mode = 2;
            din = 1'b1;
            repeat (q_hw[i]) @(negedge clk);
            if (busy_chk && i == 48) chk("busy_mid", 96'(busy), 96'd1);
            din = 1'b0;
            c_last = cyc;
            repeat ((i == n - 1) ? tail : q_lw[i]) @(negedge clk);
        end
    endtask

    task automatic run_frame(input string nm, output int dv);
        bit v;
        bit e;
        logic [95:0] f;
        int p;
        model(v, e, f);
        p = vcnt;
        send_q(RET + 10);
        dv = vcnt - p;
        chk({nm, "_valid"}, 96'(dv), 96'(v));
        chk({nm, "_err"}, 96'(err), 96'(e));
        if (v) m_frame = f;
        chk({nm, "_frame"}, frame, m_frame);
        if (v) chk({nm, "_lat"}, 96'(vcyc - c_last), 96'(RET + 2));
    endtask

    initial begin
        int dv;
        int p;
        int n;
        tbl[0] = '{96, 3, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{96, 4, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{96, 11, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{96, 12, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{96, 20, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{96, 21, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{100, 12, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{97, 8, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_frame", frame, 96'd0);
        chk("rst_valid", 96'(frame_valid), 96'd0);
        chk("rst_err", 96'(err), 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);
`ifdef WS2812B_FORWARD_EN
        chk("rst_dout", 96'(dout), 96'd0);
`endif
        reset = 1'b0;
        repeat (RET + 50) @(negedge clk);
        chk("idle_busy", 96'(busy), 96'd0);

        q_bits(96'hFF0000_00FF00_0000FF_123456, 96);
        busy_chk = 1'b1;
        run_frame("std", dv);
        busy_chk = 1'b0;
        chk("std_value", frame, 96'hFF0000_00FF00_0000FF_123456);
        chk("std_busy_end", 96'(busy), 96'd0);
        repeat (50) @(negedge clk);
        chk("std_hold", frame, 96'hFF0000_00FF00_0000FF_123456);

        q_bits(rnd96(), 95);
        run_frame("bits95", dv);

        q_bits(rnd96(), 96);
        q_hw[40] = 30;
        run_frame("long", dv);
        q_bits(rnd96(), 96);
        run_frame("after_long", dv);

        // Reset in the middle of a frame discards it.
        q_bits(rnd96(), 50);
        send_q(3);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_frame", frame, 96'd0);
        chk("mid_rst_busy", 96'(busy), 96'd0);
        chk("mid_rst_err", 96'(err), 96'd0);
        reset = 1'b0;
        m_frame = '0;
        q_bits(rnd96(), 96);
        p = vcnt;
        send_q(RET + 10);
        chk("no_ret_valid", 96'(vcnt - p), 96'd0);
        chk("no_ret_frame", frame, 96'd0);
        q_bits(rnd96(), 96);
        run_frame("post_rst", dv);

        // Reset on the very edge that would complete the frame.
        q_bits(rnd96(), 96);
        p = vcnt;
        send_q(RET + 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_frame = '0;
        chk("coinc_valid", 96'(vcnt - p), 96'd0);
        chk("coinc_frame", frame, 96'd0);
        repeat (RET + 20) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            q_bits(rnd96(), tbl[i].nb);
            q_hw[95] = tbl[i].hw;
            run_frame($sformatf("tbl%0d", i), dv);
            chk($sformatf("tbl%0d_tv", i), 96'(dv), 96'(tbl[i].v));
            chk($sformatf("tbl%0d_te", i), 96'(err), 96'(tbl[i].e));
            if (tbl[i].v)
                chk($sformatf("tbl%0d_tb", i), 96'(frame[0]), 96'(tbl[i].b));
        end

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(90, 104);
            q_hw.delete();
            q_lw.delete();
            for (int i = 0; i < n; i++) begin
                q_hw.push_back($urandom_range(MINH, MAXH));
                q_lw.push_back($urandom_range(3, 30));
            end
            if ($urandom_range(0, 1) == 1)
                q_hw[$urandom_range(0, n - 1)] = $urandom_range(1, 26);
            run_frame($sformatf("rnd%0d", k), dv);
        end

`ifdef WS2812B_FORWARD_EN
        q_bits(rnd96(), 120);
        fwd_arm = 1'b1;
        fwd_mode = 1;
        run_frame("fwd", dv);
        fwd_mode = 0;
        fwd_arm = 1'b0;
        chk("fwd_gate", 96'(bad0), 96'd0);
        chk("fwd_mirror", 96'(bad1), 96'd0);
        chk("fwd_active", 96'(fhi > 0), 96'd1);
        chk("fwd_end_low", 96'(dout), 96'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812b_decoder.md
WS2812B_DECODER -- requirements
Module: ws2812b_decoder

Interface
REQ-001 SHALL have parameter BIT_THRESH, default 60: minimum high-pulse clk count classified as a logic 1.
REQ-002 SHALL have parameter MIN_HIGH, default 20: minimum legal high-pulse clk count.
REQ-003 SHALL have parameter MAX_HIGH, default 100: maximum legal high-pulse clk count.
REQ-004 SHALL have parameter RET_CYCLES, default 5000: low clk count that defines RET/latch (50 us at 100 MHz).
REQ-005 SHALL have port clk  input  1  rising-edge system clock (100 MHz nominal).
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port din  input  1  asynchronous WS2812B serial line.
REQ-008 SHALL have port frame  output  96  last complete frame; first received bit at frame[95] (4 LEDs x GRB, MSB first).
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when frame updates.
REQ-010 SHALL have port err  output  1  sticky error for the current frame.
REQ-011 SHALL have port busy  output  1  high while a frame is being received (MEAS_HIGH or MEAS_LOW).

Function
REQ-012 SHALL pass din through a two-flop synchronizer; all timing SHALL use the synchronized signal ds.
REQ-013 SHALL implement states SYNC, IDLE, MEAS_HIGH, MEAS_LOW.
REQ-014 SYNC: ds low for RET_CYCLES consecutive cycles -> IDLE; any ds high restarts the count.
REQ-015 IDLE: ds rising -> MEAS_HIGH, high counter loaded with 1, bit counter and shift register cleared, err cleared.
REQ-016 MEAS_HIGH: count cycles while ds high; on ds falling, classify: count >= BIT_THRESH -> 1, else 0; shift bit in; -> MEAS_LOW with low counter loaded with 1.
REQ-017 High count < MIN_HIGH at falling edge, or reaching MAX_HIGH+1 while high, SHALL set err; the latter SHALL go to SYNC with no frame_valid.
REQ-018 MEAS_LOW: ds rising before RET_CYCLES -> MEAS_HIGH (next bit); low count reaching RET_CYCLES -> end of frame, -> IDLE.
REQ-019 Bit counter SHALL be 7 bits and saturate at 96; bits after the 96th SHALL NOT alter the shift register.
REQ-020 At end of frame with exactly 96 bits and err low, frame SHALL load the shift register and frame_valid SHALL pulse in the same cycle that the low count reaches RET_CYCLES.
REQ-021 At end of frame with fewer than 96 bits, err SHALL be set, frame SHALL hold, frame_valid SHALL stay low.
REQ-022 Bits beyond 96 SHALL NOT set err and SHALL NOT block frame_valid.
REQ-023 frame SHALL hold its value between frame_valid pulses.
REQ-024 err SHALL remain set until the next IDLE->MEAS_HIGH transition or reset.
REQ-025 Counters SHALL saturate and never wrap.

Reset
REQ-026 reset SHALL win over all other events in the same cycle, including a coincident RET completion.
REQ-027 On reset: state SYNC, frame 96'h0, frame_valid 0, err 0, busy 0, counters 0, synchronizer flops 0.
REQ-028 reset mid-frame SHALL discard partial data; no frame_valid SHALL follow until a new full RET-preceded frame.

Configuration
REQ-029 With macro WS2812B_FORWARD_EN defined, output dout (1 bit) SHALL exist: held low until 96 bits are captured in the current frame, then equal to ds (two-cycle latency from din), forced low again at end of frame, in SYNC and in reset (daisy-chain behaviour).
REQ-030 Without WS2812B_FORWARD_EN, dout SHALL not exist and bits beyond 96 SHALL be discarded.

Verification
REQ-031 Reset, 6000 low cycles, 96 bits of 96'hFF0000_00FF00_0000FF_123456 (1=80H/45L, 0=40H/85L), 5000 low -> frame equals that value, one frame_valid pulse, err 0.
REQ-032 Only 95 bits, then RET -> err 1, frame_valid 0, frame unchanged.
REQ-033 A high pulse of 150 cycles mid-frame -> err 1, state SYNC, no frame_valid; a following legal frame after RET is captured correctly.
REQ-034 reset asserted after bit 50, then a full legal frame -> only the second frame is reported, exact value matches.
REQ-035 WS2812B_FORWARD_EN: 120-bit stream -> first 96 bits captured; dout low for bits 1-96, mirrors bits 97-120 delayed 2 cycles; frame_valid asserted, err 0.
